osd_uart_host_peer: RTL and testbench

- Host-side counterpart of the device UART debug module; sits on the DII debug interconnect at the host interface end.
- Unpacks DII event packets arriving from the peer UART module into a byte stream for the host terminal.
- Packs host keystrokes into single-character DII event packets addressed to the peer module.
- Rejected packets are counted, not forwarded.

---
 rtl/osd_uart_host_peer_if.sv | 11 +
 rtl/osd_uart_host_peer.sv | 179 +++++++++++++++++
 tb/tb_osd_uart_host_peer.sv | 391 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/osd_uart_host_peer_if.sv
// One direction of a DII flit link: 16-bit data with valid/last, and ready
// flowing back from the sink.
interface osd_uart_host_peer_if;
  logic [15:0] data;
  logic        valid;
  logic        last;
  logic        ready;

  modport master (output data, valid, last, input ready);
  modport slave  (input data, valid, last, output ready);
endinterface

// File: rtl/osd_uart_host_peer.sv
// Host-side UART debug peer: packs host keystrokes into DII event packets and
// unpacks event packets from the device UART module into a received-character FIFO.
module osd_uart_host_peer #(
  parameter int unsigned RX_FIFO_DEPTH  = 8,
  parameter int unsigned DROP_CNT_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  osd_uart_host_peer_if.slave       debug_in,
  osd_uart_host_peer_if.master      debug_out,
  input  logic [15:0]               id,
  input  logic [15:0]               peer_id,
  input  logic [7:0]                tx_char,
  input  logic                      tx_valid,
  output logic                      tx_ready,
  output logic [7:0]                rx_char,
  output logic                      rx_valid,
  input  logic                      rx_ready,
  output logic [DROP_CNT_WIDTH-1:0] drop_count
);
  localparam int unsigned AW = $clog2(RX_FIFO_DEPTH);

  typedef enum logic [2:0] {TX_IDLE, TX_DEST, TX_SRC, TX_FLAGS, TX_DATA} tx_state_t;
  typedef enum logic [2:0] {RX_DEST, RX_SRC, RX_FLAGS, RX_PAYLOAD, RX_DISCARD} rx_state_t;

  tx_state_t tx_state, tx_next;
  logic [7:0] tx_buf;
  logic       tx_load;

  rx_state_t rx_state, rx_next;
  logic mismatch, mismatch_next;
  logic in_ready, push, pop, drop_inc;

  logic [7:0]    mem [RX_FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full;

  assign full     = (count == (AW+1)'(RX_FIFO_DEPTH));
  assign rx_valid = (count != '0);
  assign rx_char  = rx_valid ? mem[rd_ptr] : '0;
  assign pop      = rx_valid && rx_ready;
  // Ready outputs are gated by reset so every output reads 0 while rst is low.
  assign debug_in.ready = in_ready && rst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state <= TX_IDLE;
      tx_buf   <= '0;
    end else begin
      tx_state <= tx_next;
      if (tx_load) tx_buf <= tx_char;
    end
  end

  always_comb begin
    tx_next         = tx_state;
    tx_load         = 1'b0;
    tx_ready        = 1'b0;
    debug_out.valid = 1'b0;
    debug_out.data  = '0;
    debug_out.last  = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        tx_ready = rst;
        if (tx_valid) begin
          tx_load = 1'b1;
          tx_next = TX_DEST;
        end
      end
      TX_DEST: begin
        debug_out.valid = 1'b1;
        debug_out.data  = peer_id;
        if (debug_out.ready) tx_next = TX_SRC;
      end
      TX_SRC: begin
        debug_out.valid = 1'b1;
        debug_out.data  = id;
        if (debug_out.ready) tx_next = TX_FLAGS;
      end
      TX_FLAGS: begin
        debug_out.valid = 1'b1;
        debug_out.data  = 16'h8000;
        if (debug_out.ready) tx_next = TX_DATA;
      end
      TX_DATA: begin
        debug_out.valid = 1'b1;
        debug_out.data  = {8'h00, tx_buf};
        debug_out.last  = 1'b1;
        if (debug_out.ready) tx_next = TX_IDLE;
      end
      default: tx_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state   <= RX_DEST;
      mismatch   <= 1'b0;
      drop_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
    end else begin
      rx_state <= rx_next;
      mismatch <= mismatch_next;
      if (drop_inc && (drop_count != '1)) drop_count <= drop_count + DROP_CNT_WIDTH'(1);
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= debug_in.data[7:0];
  end

  // A header flit carrying last aborts the packet straight back to DEST.
  always_comb begin
    rx_next       = rx_state;
    mismatch_next = mismatch;
    in_ready      = 1'b0;
    push          = 1'b0;
    drop_inc      = 1'b0;
    case (rx_state)
      RX_DEST: begin
        in_ready = 1'b1;
        if (debug_in.valid) begin
          if (debug_in.last) drop_inc = 1'b1;
          else begin
            mismatch_next = 1'b0;
            rx_next       = RX_SRC;
          end
        end
      end
      RX_SRC: begin
        in_ready = 1'b1;
        if (debug_in.valid) begin
          if (debug_in.last) begin
            drop_inc = 1'b1;
            rx_next  = RX_DEST;
          end else begin
            mismatch_next = (debug_in.data != peer_id);
            rx_next       = RX_FLAGS;
          end
        end
      end
      RX_FLAGS: begin
        in_ready = 1'b1;
        if (debug_in.valid) begin
          if (debug_in.last) begin
            drop_inc = 1'b1;
            rx_next  = RX_DEST;
          end else if (mismatch || (debug_in.data[15:14] != 2'b10)) rx_next = RX_DISCARD;
          else rx_next = RX_PAYLOAD;
        end
      end
      RX_PAYLOAD: begin
        in_ready = !full;
        if (debug_in.valid && !full) begin
          push = 1'b1;
          if (debug_in.last) rx_next = RX_DEST;
        end
      end
      RX_DISCARD: begin
        in_ready = 1'b1;
        if (debug_in.valid && debug_in.last) begin
          drop_inc = 1'b1;
          rx_next  = RX_DEST;
        end
      end
      default: rx_next = RX_DEST;
    endcase
  end
endmodule

// File: tb/tb_osd_uart_host_peer.sv
// Bench for osd_uart_host_peer: directed scenarios plus randomized traffic
// checked against a packet-level reference model.
module tb_osd_uart_host_peer;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] id = 16'h0003;
  logic [15:0] peer_id = 16'h0005;
  logic [7:0]  tx_char = '0;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic [7:0]  rx_char;
  logic        rx_valid;
  logic        rx_ready = 1'b0;
  logic [7:0]  drop_count;

  int checks = 0;
  int failures = 0;
  int dout_mode = 0;
  int rx_mode = 0;
  int stall_err = 0;
  int flits_sent = 0;
  bit pkt_done = 1'b0;
  int exp_drop = 0;

  logic [16:0] tx_got[$];
  logic [16:0] exp_tx[$];
  logic [7:0]  rx_got[$];
  logic [7:0]  exp_rx[$];
  logic [15:0] pkt_q[$];

  osd_uart_host_peer_if din_if();
  osd_uart_host_peer_if dout_if();

  osd_uart_host_peer #(.RX_FIFO_DEPTH(8), .DROP_CNT_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .debug_in(din_if), .debug_out(dout_if),
    .id(id), .peer_id(peer_id), .tx_char(tx_char), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_char(rx_char), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    case (dout_mode)
      1:       dout_if.ready = ~dout_if.ready;
      2:       dout_if.ready = 1'($urandom_range(0, 1));
      3:       dout_if.ready = 1'b0;
      default: dout_if.ready = 1'b1;
    endcase
    if (rx_mode == 1) rx_ready = 1'($urandom_range(0, 1));
  end

  logic        p_ov = 1'b0, p_or = 1'b0, p_rv = 1'b0, p_rr = 1'b0;
  logic [16:0] p_of = '0;
  logic [7:0]  p_rc = '0;
  always @(negedge clk) begin
    if (!rst) begin
      p_ov = 1'b0;
      p_rv = 1'b0;
    end else begin
      if (p_ov && !p_or && (dout_if.valid !== 1'b1 || {dout_if.last, dout_if.data} !== p_of)) stall_err++;
      if (p_rv && !p_rr && (rx_valid !== 1'b1 || rx_char !== p_rc)) stall_err++;
      if (dout_if.valid && dout_if.ready) tx_got.push_back({dout_if.last, dout_if.data});
      if (rx_valid && rx_ready) rx_got.push_back(rx_char);
      p_ov = dout_if.valid; p_or = dout_if.ready; p_of = {dout_if.last, dout_if.data};
      p_rv = rx_valid; p_rr = rx_ready; p_rc = rx_char;
    end
  end

  // Packet-level model: a packet is accepted only if it has a full header,
  // comes from the peer and is an event; otherwise it counts as one drop.
  function automatic void model_pkt(input logic [15:0] p[$]);
    logic [15:0] flags;
    if (p.size() < 4) begin
      if (exp_drop < 255) exp_drop++;
      return;
    end
    flags = p[2];
    if (p[1] != peer_id || flags[15:14] != 2'b10) begin
      if (exp_drop < 255) exp_drop++;
    end else begin
      for (int i = 3; i < p.size(); i++) exp_rx.push_back(p[i][7:0]);
    end
  endfunction

  function automatic void model_tx(input logic [7:0] c);
    exp_tx.push_back({1'b0, peer_id});
    exp_tx.push_back({1'b0, id});
    exp_tx.push_back({1'b0, 16'h8000});
    exp_tx.push_back({1'b1, 8'h00, c});
  endfunction

  task automatic send_pkt(input logic [15:0] p[$]);
    for (int i = 0; i < p.size(); i++) begin
      int n = 0;
      bit ok = 1'b0;
      din_if.data  = p[i];
      din_if.valid = 1'b1;
      din_if.last  = (i == p.size() - 1);
      while (!ok && n < 300) begin
        @(negedge clk);
        if (din_if.ready === 1'b1) begin
          @(posedge clk); #1;
          ok = 1'b1;
        end
        n++;
      end
      if (!ok) begin
        checks++; failures++;
        $display("FAIL send_pkt_timeout got=stalled exp=accepted flit=%0d", i);
        din_if.valid = 1'b0; din_if.last = 1'b0;
        return;
      end
      flits_sent++;
    end
    din_if.valid = 1'b0;
    din_if.last  = 1'b0;
  endtask

  task automatic tx_send(input logic [7:0] c);
    int n = 0;
    bit ok = 1'b0;
    tx_char = c;
    tx_valid = 1'b1;
    while (!ok && n < 300) begin
      @(negedge clk);
      if (tx_ready === 1'b1) begin
        @(posedge clk); #1;
        ok = 1'b1;
      end
      n++;
    end
    tx_valid = 1'b0;
    if (!ok) begin
      checks++; failures++;
      $display("FAIL tx_send_timeout got=tx_ready_low exp=accepted char=%h", c);
    end else model_tx(c);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    din_if.valid = 1'b0; din_if.last = 1'b0;
    tx_valid = 1'b0; rx_mode = 0; rx_ready = 1'b0; dout_mode = 0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    tx_got.delete(); exp_tx.delete(); rx_got.delete(); exp_rx.delete();
    exp_drop = 0; stall_err = 0;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (tx_ready !== 1'b0) begin failures++; $display("FAIL reset_tx_ready got=%b exp=0", tx_ready); end
    checks++; if (din_if.ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", din_if.ready); end
    checks++; if (dout_if.valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", dout_if.valid); end
    checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL reset_rx_valid got=%b exp=0", rx_valid); end
    checks++; if (rx_char !== 8'h00) begin failures++; $display("FAIL reset_rx_char got=%h exp=00", rx_char); end
    checks++; if (drop_count !== 8'h00) begin failures++; $display("FAIL reset_drop got=%h exp=00", drop_count); end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_send();
    logic [15:0] exp_d[4];
    exp_d[0] = 16'h0005; exp_d[1] = 16'h0003; exp_d[2] = 16'h8000; exp_d[3] = 16'h0041;
    tx_char = 8'h41; tx_valid = 1'b1;
    @(negedge clk);
    checks++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL send_idle_ready got=%b exp=1", tx_ready); end
    @(posedge clk); #1;
    tx_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if ({dout_if.valid, dout_if.last, dout_if.data, tx_ready} !== {1'b1, (k == 3), exp_d[k], 1'b0}) begin
        failures++;
        $display("FAIL send_flit%0d got=v%b l%b d%h r%b exp=v1 l%b d%h r0", k, dout_if.valid,
                 dout_if.last, dout_if.data, tx_ready, (k == 3), exp_d[k]);
      end
    end
    @(negedge clk);
    checks++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL send_back_idle got=%b exp=1", tx_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int n = 0;
    tx_got.delete(); exp_tx.delete(); stall_err = 0;
    dout_mode = 1;
    tx_send(8'h41);
    while (tx_got.size() < 4 && n < 60) begin @(negedge clk); n++; end
    checks++; if (tx_got.size() != 4) begin failures++; $display("FAIL bp_count got=%0d exp=4", tx_got.size()); end
    for (int i = 0; i < 4 && i < tx_got.size(); i++) begin
      checks++;
      if (tx_got[i] !== exp_tx[i]) begin failures++; $display("FAIL bp_flit%0d got=%h exp=%h", i, tx_got[i], exp_tx[i]); end
    end
    checks++; if (stall_err != 0) begin failures++; $display("FAIL bp_stable got=%0d exp=0", stall_err); end
    dout_mode = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_receive();
    logic [15:0] p[$];
    do_reset();
    rx_ready = 1'b1;
    p = {16'h0003, 16'h0005, 16'h8000, 16'h0048, 16'h0069};
    model_pkt(p);
    send_pkt(p);
    repeat (4) @(negedge clk);
    checks++; if (rx_got.size() != exp_rx.size()) begin failures++; $display("FAIL rx_count got=%0d exp=%0d", rx_got.size(), exp_rx.size()); end
    for (int i = 0; i < exp_rx.size() && i < rx_got.size(); i++) begin
      checks++;
      if (rx_got[i] !== exp_rx[i]) begin failures++; $display("FAIL rx_char%0d got=%h exp=%h", i, rx_got[i], exp_rx[i]); end
    end
    checks++; if (drop_count !== 8'(exp_drop)) begin failures++; $display("FAIL rx_drop got=%0d exp=%0d", drop_count, exp_drop); end
    @(posedge clk); #1;
  endtask

  task automatic test_reject_src();
    logic [15:0] p[$];
    do_reset();
    rx_ready = 1'b1;
    p = {16'h0003, 16'h0007, 16'h8000, 16'h0041};
    model_pkt(p);
    send_pkt(p);
    repeat (3) @(negedge clk);
    checks++; if (rx_got.size() != 0) begin failures++; $display("FAIL rej_src_rx got=%0d exp=0", rx_got.size()); end
    checks++; if (drop_count !== 8'(exp_drop)) begin failures++; $display("FAIL rej_src_drop got=%0d exp=%0d", drop_count, exp_drop); end
    @(posedge clk); #1;
  endtask

  task automatic test_reject_short();
    logic [15:0] p[$];
    do_reset();
    rx_ready = 1'b1;
    p = {16'h0003, 16'h0005};
    model_pkt(p); send_pkt(p);
    p = {16'h0003, 16'h0005, 16'h8000, 16'h0042};
    model_pkt(p); send_pkt(p);
    repeat (3) @(negedge clk);
    checks++; if (drop_count !== 8'(exp_drop)) begin failures++; $display("FAIL short_drop got=%0d exp=%0d", drop_count, exp_drop); end
    checks++; if (rx_got.size() != exp_rx.size()) begin failures++; $display("FAIL short_rx_count got=%0d exp=%0d", rx_got.size(), exp_rx.size()); end
    if (rx_got.size() > 0 && exp_rx.size() > 0) begin
      checks++; if (rx_got[0] !== exp_rx[0]) begin failures++; $display("FAIL short_rx_char got=%h exp=%h", rx_got[0], exp_rx[0]); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_fifo_full();
    int n = 0;
    do_reset();
    pkt_q = {16'h0003, 16'h0005, 16'h8000};
    for (int i = 0; i < 10; i++) pkt_q.push_back({8'($urandom), 8'($urandom)});
    model_pkt(pkt_q);
    flits_sent = 0; pkt_done = 1'b0;
    fork
      begin send_pkt(pkt_q); pkt_done = 1'b1; end
    join_none
    repeat (30) @(negedge clk);
    checks++; if (flits_sent != 11) begin failures++; $display("FAIL full_accepted got=%0d exp=11", flits_sent); end
    checks++; if (din_if.ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%b exp=0", din_if.ready); end
    checks++; if (rx_valid !== 1'b1 || rx_char !== exp_rx[0]) begin failures++; $display("FAIL full_head got=v%b %h exp=v1 %h", rx_valid, rx_char, exp_rx[0]); end
    @(posedge clk); #1;
    rx_ready = 1'b1;
    while (!pkt_done && n < 200) begin @(negedge clk); n++; end
    checks++; if (!pkt_done) begin failures++; $display("FAIL full_drain got=stuck exp=done"); end
    repeat (15) @(negedge clk);
    checks++; if (rx_got.size() != 10) begin failures++; $display("FAIL full_count got=%0d exp=10", rx_got.size()); end
    for (int i = 0; i < exp_rx.size() && i < rx_got.size(); i++) begin
      checks++;
      if (rx_got[i] !== exp_rx[i]) begin failures++; $display("FAIL full_char%0d got=%h exp=%h", i, rx_got[i], exp_rx[i]); end
    end
    checks++; if (stall_err != 0) begin failures++; $display("FAIL full_stable got=%0d exp=0", stall_err); end
    @(posedge clk); #1;
  endtask

  task automatic test_drop_saturate();
    logic [15:0] p[$];
    do_reset();
    rx_ready = 1'b1;
    for (int k = 0; k < 260; k++) begin
      p = {16'h0003};
      model_pkt(p);
      send_pkt(p);
      if (k == 253) begin
        @(negedge clk);
        checks++; if (drop_count !== 8'(exp_drop)) begin failures++; $display("FAIL drop_254 got=%0d exp=%0d", drop_count, exp_drop); end
        @(posedge clk); #1;
      end
    end
    @(negedge clk);
    checks++; if (drop_count !== 8'(exp_drop)) begin failures++; $display("FAIL drop_sat got=%0d exp=%0d", drop_count, exp_drop); end
    checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL drop_rx got=%b exp=0", rx_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int n = 0;
    do_reset();
    rx_mode = 1;
    dout_mode = 2;
    fork
      begin
        for (int k = 0; k < 20; k++) begin
          tx_send(8'($urandom));
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end
      end
      begin
        for (int k = 0; k < 25; k++) begin
          logic [15:0] p[$];
          int len;
          len = $urandom_range(1, 7);
          p.delete();
          p.push_back(16'($urandom));
          if (len > 1) p.push_back(($urandom_range(0, 3) == 0) ? 16'h0007 : peer_id);
          if (len > 2) p.push_back(($urandom_range(0, 3) == 0) ? {2'b01, 14'($urandom)} : {2'b10, 14'($urandom)});
          for (int i = 3; i < len; i++) p.push_back(16'($urandom));
          model_pkt(p);
          send_pkt(p);
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
      end
    join
    while (n < 1000 && !(tx_ready === 1'b1 && rx_valid === 1'b0 && tx_got.size() == exp_tx.size())) begin
      @(negedge clk); n++;
    end
    checks++; if (tx_got.size() != exp_tx.size()) begin failures++; $display("FAIL rnd_tx_count got=%0d exp=%0d", tx_got.size(), exp_tx.size()); end
    for (int i = 0; i < exp_tx.size() && i < tx_got.size(); i++) begin
      checks++;
      if (tx_got[i] !== exp_tx[i]) begin failures++; $display("FAIL rnd_tx%0d got=%h exp=%h", i, tx_got[i], exp_tx[i]); end
    end
    checks++; if (rx_got.size() != exp_rx.size()) begin failures++; $display("FAIL rnd_rx_count got=%0d exp=%0d", rx_got.size(), exp_rx.size()); end
    for (int i = 0; i < exp_rx.size() && i < rx_got.size(); i++) begin
      checks++;
      if (rx_got[i] !== exp_rx[i]) begin failures++; $display("FAIL rnd_rx%0d got=%h exp=%h", i, rx_got[i], exp_rx[i]); end
    end
    checks++; if (drop_count !== 8'(exp_drop)) begin failures++; $display("FAIL rnd_drop got=%0d exp=%0d", drop_count, exp_drop); end
    checks++; if (stall_err != 0) begin failures++; $display("FAIL rnd_stable got=%0d exp=0", stall_err); end
    rx_mode = 0;
    dout_mode = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    logic [15:0] p[$];
    do_reset();
    rx_ready = 1'b0;
    p = {16'h0003, 16'h0005, 16'h8000, 16'h0011, 16'h0022};
    model_pkt(p);
    send_pkt(p);
    dout_mode = 3;
    dout_if.ready = 1'b0;
    tx_send(8'h7E);
    repeat (2) begin @(posedge clk); #1; end
    checks++; if (dout_if.valid !== 1'b1 || rx_valid !== 1'b1 || rx_char !== 8'h11) begin
      failures++; $display("FAIL mid_pre got=v%b rv%b %h exp=v1 rv1 11", dout_if.valid, rx_valid, rx_char);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL mid_rx_valid got=%b exp=0", rx_valid); end
    checks++; if (dout_if.valid !== 1'b0) begin failures++; $display("FAIL mid_out_valid got=%b exp=0", dout_if.valid); end
    checks++; if (tx_ready !== 1'b0 || din_if.ready !== 1'b0) begin failures++; $display("FAIL mid_readies got=%b%b exp=00", tx_ready, din_if.ready); end
    @(posedge clk); #1;
    rst = 1'b1;
    dout_mode = 0;
    @(negedge clk);
    checks++; if ({tx_ready, rx_valid, dout_if.valid} !== 3'b100) begin
      failures++; $display("FAIL mid_after got=%b exp=100", {tx_ready, rx_valid, dout_if.valid});
    end
  endtask

  initial begin
    din_if.data = '0;
    din_if.valid = 1'b0;
    din_if.last = 1'b0;
    dout_if.ready = 1'b1;
    test_reset();
    test_send();
    test_backpressure();
    test_receive();
    test_reject_src();
    test_reject_short();
    test_fifo_full();
    test_drop_saturate();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
